// File: rtl/fpcvt_pkg.sv
// Shared types and constants for the 12-bit fixed to 8-bit float conversion sequencer.
package fpcvt_pkg;
  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'b1111;

  typedef enum logic [2:0] {IDLE, MAG, NORM, ROUND, OUT} state_e;
endpackage

// File: rtl/fpcvt_round_step.sv
// Round-half-up of the normalized significand, with exponent carry and saturation at the top.
module fpcvt_round_step import fpcvt_pkg::*; (
  input  logic [EXP_W-1:0] e_i,
  input  logic [SIG_W-1:0] f_i,
  input  logic             fifth_i,
  output logic [EXP_W-1:0] exp_o,
  output logic [SIG_W-1:0] sig_o
);
  always_comb begin
    exp_o = e_i;
    sig_o = f_i;
    if (fifth_i) begin
      if (f_i != SIG_MAX) begin
        sig_o = f_i + SIG_W'(1);
      end else if (e_i != EXP_MAX) begin
        // 1111 + 1 overflows: renormalize to 1000 one octave up
        sig_o = {1'b1, {(SIG_W-1){1'b0}}};
        exp_o = e_i + EXP_W'(1);
      end else begin
        sig_o = SIG_MAX;
        exp_o = EXP_MAX;
      end
    end
  end
endmodule

// File: rtl/fpcvt_seq_ctrl.sv
// Multi-cycle sequencer: accept sample, take magnitude, normalize one bit per cycle,
// round, then hold the packed float until the consumer takes it.
module fpcvt_seq_ctrl import fpcvt_pkg::*; #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output logic             busy
);
  localparam int MAG_W = IN_W - 1;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  din_q, din_d;
  logic             sgn_q, sgn_d;
  logic [MAG_W-1:0] sh_q, sh_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic [IN_W-1:0]  neg;
  logic [MAG_W-1:0] mag;
  logic [EXP_W-1:0] rnd_exp;
  logic [SIG_W-1:0] rnd_sig;

  assign neg = -din_q;

  // The most negative sample has no positive 11-bit counterpart; clamp it.
  always_comb begin
    mag = sgn_q ? neg[MAG_W-1:0] : din_q[MAG_W-1:0];
    if (din_q == {1'b1, {MAG_W{1'b0}}}) mag = '1;
  end

  fpcvt_round_step u_round (
    .e_i     (e_q),
    .f_i     (sh_q[MAG_W-1 -: SIG_W]),
    .fifth_i (sh_q[MAG_W-1-SIG_W]),
    .exp_o   (rnd_exp),
    .sig_o   (rnd_sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      sgn_q   <= 1'b0;
      sh_q    <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      sgn_q   <= sgn_d;
      sh_q    <= sh_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    sgn_d   = sgn_q;
    sh_d    = sh_q;
    e_d     = e_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: if (in_valid) begin
        din_d   = d_in;
        sgn_d   = d_in[IN_W-1];
        state_d = MAG;
      end
      MAG: begin
        sh_d    = mag;
        e_d     = EXP_MAX;
        state_d = NORM;
      end
      NORM: begin
        if (sh_q[MAG_W-1] || e_q == '0) begin
          state_d = ROUND;
        end else begin
          sh_d = {sh_q[MAG_W-2:0], 1'b0};
          e_d  = e_q - EXP_W'(1);
        end
      end
      ROUND: begin
        sign_d  = sgn_q;
        exp_d   = rnd_exp;
        sig_d   = rnd_sig;
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == MAG) || (state_q == NORM) || (state_q == ROUND);
  assign sign      = sign_q;
  assign exp       = exp_q;
  assign sig       = sig_q;
endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Bench for fpcvt_seq_ctrl: vector table through a result scoreboard, plus hold and abort sequences.
module tb_fpcvt_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] d_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign;
  logic [2:0]  exp;
  logic [3:0]  sig;
  logic        busy;

  fpcvt_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .exp       (exp),
    .sig       (sig),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] din;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  g;
    int          lat;
  } vec_t;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] g;
  } res_t;

  res_t sbq[$];
  res_t last_res;
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Accept one sample, wait for the result, compare against the scoreboard; leaves DUT in OUT.
  task automatic convert(input vec_t v);
    int   cnt;
    bit   bad;
    res_t r;
    chk($sformatf("in_ready_before_%h", v.din), int'(in_ready), 1);
    in_valid = 1'b1;
    d_in     = v.din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r.s = v.s; r.e = v.e; r.g = v.g;
    sbq.push_back(r);
    cnt = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && cnt < 16) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    chk($sformatf("busy_during_%h", v.din), int'(bad), 0);
    chk($sformatf("out_valid_%h", v.din), int'(out_valid), 1);
    chk($sformatf("latency_%h", v.din), cnt, v.lat);
    chk($sformatf("busy_in_out_%h", v.din), int'(busy), 0);
    if (out_valid === 1'b1 && sbq.size() > 0) begin
      r = sbq.pop_front();
      chk($sformatf("sign_%h", v.din), int'(sign), int'(r.s));
      chk($sformatf("exp_%h", v.din), int'(exp), int'(r.e));
      chk($sformatf("sig_%h", v.din), int'(sig), int'(r.g));
      last_res = r;
    end
  endtask

  // Consume the result; outputs must be retained after out_valid drops.
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    chk("retain_sign", int'(sign), int'(last_res.s));
    chk("retain_exp", int'(exp), int'(last_res.e));
    chk("retain_sig", int'(sig), int'(last_res.g));
  endtask

  initial begin
    vec_t zv;
    bit   bad;

    vecs[0] = '{12'h1A6, 1'b0, 3'd5, 4'b1101, 5};
    vecs[1] = '{12'hE5A, 1'b1, 3'd5, 4'b1101, 5};
    vecs[2] = '{12'h03E, 1'b0, 3'd3, 4'b1000, 8};
    vecs[3] = '{12'h7FF, 1'b0, 3'd7, 4'b1111, 3};
    vecs[4] = '{12'h800, 1'b1, 3'd7, 4'b1111, 3};
    vecs[5] = '{12'h001, 1'b0, 3'd0, 4'b0001, 10};
    vecs[6] = '{12'hFFF, 1'b1, 3'd0, 4'b0001, 10};
    vecs[7] = '{12'h3C0, 1'b0, 3'd6, 4'b1111, 4};
    vecs[8] = '{12'h01F, 1'b0, 3'd2, 4'b1000, 9};
    vecs[9] = '{12'h4C0, 1'b0, 3'd7, 4'b1010, 3};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sign", int'(sign), 0);
    chk("rst_exp", int'(exp), 0);
    chk("rst_sig", int'(sig), 0);

    foreach (vecs[i]) begin
      convert(vecs[i]);
      release_out();
    end

    // Abort mid-NORM: no result may follow and outputs are cleared.
    in_valid = 1'b1;
    d_in     = 12'h005;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_exp", int'(exp), 0);
    chk("abort_sig", int'(sig), 0);
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_result", int'(bad), 0);

    // Zero input at worst-case latency, then a stalled consumer.
    out_ready = 1'b0;
    zv = '{12'h000, 1'b0, 3'd0, 4'b0000, 10};
    convert(zv);
    bad = 1'b0;
    repeat (4) begin
      in_valid = 1'b1;
      d_in     = 12'h123;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sign !== 1'b0 ||
          exp !== 3'd0 || sig !== 4'b0000) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("hold_stable", int'(bad), 0);
    release_out();
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("hold_pulses_ignored", int'(bad), 0);

    convert(vecs[0]);
    release_out();

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpcvt_seq_ctrl.md
Name: fpcvt_seq_ctrl

Overview:
Multi-cycle sequencer for the 12-bit two's-complement to 8-bit float converter (1 sign, 3-bit exponent, 4-bit significand).
- Accepts one sample over a valid/ready handshake, then steps MAG -> NORM -> ROUND.
- Holds the packed result until the consumer takes it.
- Sits between the switch/sample front-end and the display/encoder stage, and owns sequencing of the rounding step.

Parameters:
IN_W, 12, input sample width; only default supported
EXP_W, 3, exponent width; only default supported
SIG_W, 4, significand width; only default supported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  d_in is valid
in_ready  output  1  block can accept a sample; high only in IDLE
d_in  input  12  two's-complement sample
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts the result
sign  output  1  result sign
exp  output  3  result exponent
sig  output  4  result significand
busy  output  1  high in MAG, NORM, ROUND

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; sign=0; exp=0; sig=0; internal registers cleared.
- rst has priority over everything. Asserting rst mid-operation aborts the conversion and drops any pending result; no output pulse follows.
- IDLE: in_valid&in_ready accepts the sample. Latch sign=d_in[11] and d_in, then go to MAG.
- MAG: mag = sign ? -d_in : d_in, truncated to 11 bits.
  - d_in=0x800 saturates mag to 0x7FF.
  - Load sh[10:0]=mag and e=7, then go to NORM.
- NORM, one decision per cycle:
  - If sh[10]==1 or e==0, go to ROUND.
  - Otherwise shift sh left by 1 (zero fill) and decrement e.
  - At most 7 shifts.
- ROUND: take f=sh[10:7] and fifth=sh[6].
  - fifth=0: sig=f, exp=e.
  - fifth=1 and f!=1111: sig=f+1, exp=e.
  - fifth=1, f==1111, e<7: sig=1000, exp=e+1.
  - fifth=1, f==1111, e==7: saturate to sig=1111, exp=7.
  - Register sign/exp/sig, set out_valid=1, go to OUT.
- OUT: outputs stable while out_valid=1.
  - out_ready=1 clears out_valid and returns to IDLE on the same edge.
  - A new sample cannot be accepted until the next cycle, because in_ready=0 outside IDLE.
- Latency: out_valid rises n+3 edges after the accepting edge, where n = number of NORM shifts (0..7). Worst case is 10 edges.
- Output values after OUT are retained until the next ROUND; only out_valid marks them valid.
- Zero input: sign=0, exp=0, sig=0000.

Decomposition:
- Shared package fpcvt_pkg holds:
  - state enum (IDLE, MAG, NORM, ROUND, OUT)
  - IN_W/EXP_W/SIG_W constants
  - EXP_MAX=7 and SIG_MAX=4'b1111
- One combinational sub-module, fpcvt_round_step (inputs e, f, fifth; outputs exp, sig). It is instantiated in ROUND, which keeps the saturation rules unit-testable.
- Controller FSM and shift datapath stay in fpcvt_seq_ctrl.

Test Plan:
- d_in=0x1A6 (422), out_ready=1 -> sign=0, exp=5, sig=1101; out_valid exactly 5 edges after acceptance.
- d_in=0xE5A (-422) -> sign=1, exp=5, sig=1101; busy high throughout the conversion.
- d_in=0x03E (62) -> round carry: sign=0, exp=3, sig=1000.
- d_in=0x7FF and d_in=0x800 -> both exp=7, sig=1111, with sign 0 and 1 respectively; 0x800 takes 3 edges.
- d_in=0x000 -> exp=0, sig=0000, 10-edge latency. Then hold out_ready=0 for 4 cycles -> out_valid and outputs stable, in_ready=0, and in_valid pulses are ignored.
- Assert rst during NORM of d_in=0x005 -> next cycle state IDLE, in_ready=1, out_valid=0, no result emitted.
